// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter on the core data bus: TX FIFO, baud counter and frame FSM.
// Register window: TXDATA (push), STATUS, BAUDDIV, reserved; reads are combinational.
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0100,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned DEFAULT_DIV = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A_mem,
    input  logic [31:0] DataIP,
    input  logic        MemRW,
    output logic [31:0] D_read,
    output logic        tx
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned DIV_W = 16;

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic [DIV_W-1:0] baud_div;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] baud_cnt, cnt_nxt;
    logic [2:0]       bit_idx, idx_nxt;
    logic [7:0]       shift, shift_nxt;
    logic             tx_nxt;

    logic       hit_c, wr_c, push_req_c, push_ok_c, pop_c, full_c, empty_c;
    logic [1:0] offset_c;
    logic [DIV_W-1:0] reload_c;
    logic       unused_c;

    // Address decode and FIFO flags
    assign hit_c      = (A_mem[31:4] == BASE_ADDR[31:4]);
    assign offset_c   = A_mem[3:2];
    assign wr_c       = hit_c && MemRW;
    assign push_req_c = wr_c && (offset_c == 2'd0);
    assign full_c     = (count == CNT_W'(FIFO_DEPTH));
    assign empty_c    = (count == '0);
    assign push_ok_c  = push_req_c && (!full_c || pop_c);
    assign reload_c   = baud_div - DIV_W'(1);
    assign unused_c   = ^{DataIP[31:16], A_mem[1:0]};

    // Frame FSM: next state, counter reloads, shift register and registered tx value
    always_comb begin
        state_nxt = state;
        cnt_nxt   = baud_cnt;
        idx_nxt   = bit_idx;
        shift_nxt = shift;
        tx_nxt    = tx;
        pop_c     = 1'b0;
        case (state)
            ST_IDLE: begin
                tx_nxt = 1'b1;
                if (!empty_c) begin
                    pop_c     = 1'b1;
                    shift_nxt = fifo_mem[rd_ptr];
                    tx_nxt    = 1'b0;
                    cnt_nxt   = reload_c;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (baud_cnt != '0) begin
                    cnt_nxt = baud_cnt - DIV_W'(1);
                end else begin
                    state_nxt = ST_DATA;
                    idx_nxt   = 3'd0;
                    tx_nxt    = shift[0];
                    shift_nxt = {1'b0, shift[7:1]};
                    cnt_nxt   = reload_c;
                end
            end
            ST_DATA: begin
                if (baud_cnt != '0) begin
                    cnt_nxt = baud_cnt - DIV_W'(1);
                end else if (bit_idx == 3'd7) begin
                    state_nxt = ST_STOP;
                    tx_nxt    = 1'b1;
                    cnt_nxt   = reload_c;
                end else begin
                    idx_nxt   = bit_idx + 3'd1;
                    tx_nxt    = shift[0];
                    shift_nxt = {1'b0, shift[7:1]};
                    cnt_nxt   = reload_c;
                end
            end
            ST_STOP: begin
                if (baud_cnt != '0) begin
                    cnt_nxt = baud_cnt - DIV_W'(1);
                end else if (!empty_c) begin
                    // Next byte starts immediately so frames stay contiguous
                    pop_c     = 1'b1;
                    shift_nxt = fifo_mem[rd_ptr];
                    tx_nxt    = 1'b0;
                    cnt_nxt   = reload_c;
                    state_nxt = ST_START;
                end else begin
                    tx_nxt    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                tx_nxt    = 1'b1;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_nxt;
            baud_cnt <= cnt_nxt;
            bit_idx  <= idx_nxt;
            shift    <= shift_nxt;
            tx       <= tx_nxt;
        end
    end

    // FIFO storage; contents are don't-care until pushed
    always_ff @(posedge clk) begin
        if (push_ok_c) fifo_mem[wr_ptr] <= DataIP[7:0];
    end

    // FIFO pointers, count, overflow flag and baud divisor
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            baud_div <= DIV_W'(DEFAULT_DIV);
        end else begin
            if (push_ok_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)     rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok_c, pop_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (push_req_c && !push_ok_c) begin
                overflow <= 1'b1;
            end else if (wr_c && (offset_c == 2'd1) && DataIP[3]) begin
                overflow <= 1'b0;
            end
            if (wr_c && (offset_c == 2'd2)) begin
                baud_div <= (DataIP[15:0] < DIV_W'(2)) ? DIV_W'(2) : DataIP[15:0];
            end
        end
    end

    // Combinational read mux
    always_comb begin
        D_read = 32'h0;
        if (hit_c) begin
            case (offset_c)
                2'd1:    D_read = {16'h0, 8'(count), 4'h0, overflow, empty_c, full_c,
                                   (state != ST_IDLE)};
                2'd2:    D_read = {16'h0, baud_div};
                default: D_read = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: register-map vector table plus hand-written frame,
// overflow, async-reset and baud-change sequences.
module tb_uart_tx_mmio;

    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam logic [31:0] TXD  = BASE;
    localparam logic [31:0] STS  = BASE + 32'h4;
    localparam logic [31:0] BDV  = BASE + 32'h8;
    localparam logic [31:0] RSV  = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] A_mem, DataIP, D_read;
    logic        MemRW;
    logic        tx;

    int total = 0;
    int bad   = 0;

    uart_tx_mmio #(.BASE_ADDR(BASE), .FIFO_DEPTH(4), .DEFAULT_DIV(16)) dut (
        .clk(clk), .rst(rst), .A_mem(A_mem), .DataIP(DataIP),
        .MemRW(MemRW), .D_read(D_read), .tx(tx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [31:0] raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        A_mem  = a;
        DataIP = d;
        MemRW  = 1'b1;
        @(posedge clk);
        #1;
        MemRW  = 1'b0;
        A_mem  = 32'h0;
        DataIP = 32'h0;
    endtask

    task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp, input string name);
        A_mem = a;
        MemRW = 1'b0;
        #1;
        chk(name, D_read, exp);
        A_mem = 32'h0;
    endtask

    task automatic tx_expect(input logic v, input int n, input string name);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            chk(name, 32'(tx), 32'(v));
        end
    endtask

    task automatic check_frame(input logic [7:0] b, input int div, input int skip,
                               input string name);
        tx_expect(1'b0, div - skip, {name, "_start"});
        for (int i = 0; i < 8; i++) tx_expect(b[i], div, $sformatf("%s_bit%0d", name, i));
        tx_expect(1'b1, div, {name, "_stop"});
    endtask

    // Waits (bounded) for a start bit, then samples each bit on its first cycle
    task automatic rx_byte(input int div, input logic [7:0] exp, input string name);
        int n;
        logic [7:0] got;
        n = 0;
        got = 8'h0;
        while (tx !== 1'b0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_start_seen"}, 32'(tx), 32'h0);
        if (tx === 1'b0) begin
            for (int i = 0; i < 8; i++) begin
                repeat (div) @(posedge clk);
                #1;
                got[i] = tx;
            end
            repeat (div) @(posedge clk);
            #1;
            chk({name, "_stopbit"}, 32'(tx), 32'h1);
            chk({name, "_byte"}, 32'(got), 32'(exp));
        end
    endtask

    initial begin
        vecs[0]  = '{1'b0, 32'h0,         32'h0,          STS,                 32'h4};
        vecs[1]  = '{1'b0, 32'h0,         32'h0,          TXD,                 32'h0};
        vecs[2]  = '{1'b0, 32'h0,         32'h0,          BDV,                 32'd16};
        vecs[3]  = '{1'b0, 32'h0,         32'h0,          RSV,                 32'h0};
        vecs[4]  = '{1'b0, 32'h0,         32'h0,          BASE + 32'h10,       32'h0};
        vecs[5]  = '{1'b0, 32'h0,         32'h0,          BASE - 32'h4,        32'h0};
        vecs[6]  = '{1'b0, 32'h0,         32'h0,          BASE + 32'hB,        32'd16};
        vecs[7]  = '{1'b1, BDV,           32'h0,          BDV,                 32'd2};
        vecs[8]  = '{1'b1, BDV,           32'h1,          BDV,                 32'd2};
        vecs[9]  = '{1'b1, BDV,           32'h0001_2345,  BDV,                 32'h2345};
        vecs[10] = '{1'b1, RSV,           32'hFF,         RSV,                 32'h0};
        vecs[11] = '{1'b1, BASE + 32'h10, 32'h41,         STS,                 32'h4};
        vecs[12] = '{1'b1, STS,           32'hFFFF_FFF7,  STS,                 32'h4};
        vecs[13] = '{1'b1, BDV,           32'h3,          BASE + 32'hA,        32'h3};
        vecs[14] = '{1'b1, BASE + 32'h20, 32'h55,         STS,                 32'h4};

        rst    = 1'b1;
        A_mem  = 32'h0;
        DataIP = 32'h0;
        MemRW  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx", 32'(tx), 32'h1);
        rst = 1'b0;

        // Register map vectors
        for (int i = 0; i < 15; i++) begin
            if (vecs[i].we) wr(vecs[i].waddr, vecs[i].wdata);
            rd_chk(vecs[i].raddr, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Single frame, div 4, with busy boundary
        wr(BDV, 32'd4);
        wr(TXD, 32'h55);
        check_frame(8'h55, 4, 0, "f55");
        rd_chk(STS, 32'h5, "f55_busy_last");
        @(posedge clk);
        #1;
        rd_chk(STS, 32'h4, "f55_idle");

        // Back-to-back frames, div 2
        wr(BDV, 32'd2);
        wr(TXD, 32'hA3);
        wr(TXD, 32'h0F);
        chk("fA3_latency", 32'(tx), 32'h0);
        check_frame(8'hA3, 2, 1, "fA3");
        rd_chk(STS, 32'h101, "fA3_sts");
        check_frame(8'h0F, 2, 0, "f0F");
        rd_chk(STS, 32'h5, "f0F_sts_empty");
        @(posedge clk);
        #1;
        rd_chk(STS, 32'h4, "f0F_idle");

        // Overflow: one active frame plus five pushes into a 4-deep FIFO
        wr(TXD, 32'hFF);
        wr(TXD, 32'h12);
        wr(TXD, 32'h34);
        wr(TXD, 32'hC5);
        wr(TXD, 32'h7E);
        wr(TXD, 32'h99);
        rd_chk(STS, 32'h40B, "ovf_set");
        wr(STS, 32'h7);
        rd_chk(STS, 32'h40B, "ovf_keep");
        wr(STS, 32'h8);
        rd_chk(STS, 32'h403, "ovf_clear");
        rx_byte(2, 8'h12, "rx12");
        rx_byte(2, 8'h34, "rx34");
        rx_byte(2, 8'hC5, "rxC5");
        rx_byte(2, 8'h7E, "rx7E");
        tx_expect(1'b1, 40, "ovf_dropped");
        rd_chk(STS, 32'h4, "ovf_idle");

        // Baud change mid-frame: start bit keeps 4, later bits use 8
        wr(BDV, 32'd4);
        wr(TXD, 32'h0F);
        tx_expect(1'b0, 1, "bc_start");
        wr(BDV, 32'd8);
        chk("bc_start_w", 32'(tx), 32'h0);
        tx_expect(1'b0, 2, "bc_start");
        for (int i = 0; i < 8; i++) tx_expect((i < 4) ? 1'b1 : 1'b0, 8, $sformatf("bc_bit%0d", i));
        tx_expect(1'b1, 8, "bc_stop");
        rd_chk(BDV, 32'd8, "bc_div");
        rd_chk(STS, 32'h5, "bc_busy_last");
        @(posedge clk);
        #1;
        rd_chk(STS, 32'h4, "bc_idle");

        // Async reset mid-DATA with three bytes queued
        wr(BDV, 32'd4);
        wr(TXD, 32'h00);
        wr(TXD, 32'hAA);
        wr(TXD, 32'hBB);
        wr(TXD, 32'hCC);
        repeat (8) @(posedge clk);
        #1;
        chk("pre_rst_tx", 32'(tx), 32'h0);
        rd_chk(STS, 32'h301, "pre_rst_sts");
        #2;
        rst = 1'b1;
        #1;
        chk("rst_tx_async", 32'(tx), 32'h1);
        rd_chk(STS, 32'h4, "rst_sts");
        rd_chk(BDV, 32'd16, "rst_div");
        @(posedge clk);
        #1;
        rst = 1'b0;
        tx_expect(1'b1, 200, "rst_no_frame");
        rd_chk(STS, 32'h4, "rst_sts_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter that responds to the RV32 core's data-memory bus (A_mem/DataIP/MemRW/D_read).
- Sits beside Data_mem and decodes its own address window.
- Core stores push bytes into a small FIFO. A baud counter and frame FSM serialize each byte as 8N1 on `tx`, LSB first.
- Core loads return status and configuration. Reads are combinational, matching the single-cycle data path.

Parameters:
- BASE_ADDR, 32'h0000_0100, base of the 16-byte register window; bits [3:0] must be 0.
- FIFO_DEPTH, 4, TX FIFO entries; power of two, 2..16.
- DEFAULT_DIV, 16, clocks per serial bit after reset.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- A_mem  in  32  byte address from the core ALU result.
- DataIP  in  32  store data (rs2).
- MemRW  in  1  1 = write this cycle, 0 = read.
- D_read  out  32  read data; 0 when the address is outside the window.
- tx  out  1  serial line; idles high.

Behaviour:
- Decode: hit = (A_mem[31:4] == BASE_ADDR[31:4]). The offset is A_mem[3:2]; A_mem[1:0] is ignored.
- Register map:
  - offset 0, TXDATA: write pushes DataIP[7:0]; reads return 0.
  - offset 1, STATUS: bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), bits[15:8] FIFO count, other bits 0. Writing with DataIP[3]=1 clears overflow; other bits are read-only.
  - offset 2, BAUDDIV: bits[15:0] hold clocks per bit. A written value of 0 or 1 is stored as 2. Reads return the stored value zero-extended.
  - offset 3: reserved; reads 0, writes ignored.
- Reads: D_read is combinational from A_mem and current register state; no clock latency.
- Writes: take effect at the rising edge of clk when MemRW=1 and hit.
- Reset (async, any time including mid-frame):
  - tx=1, FIFO empty (count 0), overflow=0, BAUDDIV=DEFAULT_DIV, FSM=IDLE, baud counter=0, bit index=0.
  - D_read reflects the reset state immediately.
- FIFO:
  - Circular buffer with read and write pointers that wrap modulo FIFO_DEPTH.
  - A push is accepted if not full, or if a pop occurs in the same cycle.
  - A push to a full FIFO with no simultaneous pop is dropped and sets overflow.
  - On a simultaneous push and pop, count is unchanged and the data order is preserved.
- FSM states:
  - IDLE: tx=1. If the FIFO is non-empty at a clk edge, pop the head into the shift register, drive tx=0 (registered), load the baud counter with BAUDDIV-1, and go to START.
  - START: tx=0 for BAUDDIV cycles. On counter==0, go to DATA with bit index 0 and drive tx=shift[0].
  - DATA: each bit lasts BAUDDIV cycles, LSB first. After bit 7 expires, go to STOP with tx=1.
  - STOP: tx=1 for BAUDDIV cycles. On expiry:
    - if the FIFO is non-empty, pop and go directly to START (no idle gap);
    - otherwise go to IDLE.
- Latency: a TXDATA write at edge N into an empty FIFO with FSM=IDLE gives tx=0 after edge N+1. Each frame is exactly 10*BAUDDIV cycles. Back-to-back frames are contiguous.
- tx is driven from a flop; it never glitches.
- BAUDDIV changes take effect at the next counter reload (bit boundary). The bit currently in flight keeps its old length.
- Writes to TXDATA while busy are legal and only enqueue.

Test Plan:
- Reset, then write BAUDDIV=4 and TXDATA=0x55 → tx low starting 1 cycle after the write edge. Then 4-cycle bits 1,0,1,0,1,0,1,0, then 4 cycles high. busy deasserts 40 cycles after tx falls.
- With BAUDDIV=2, write 0xA3 then 0x0F on consecutive cycles → two contiguous 20-cycle frames, no idle gap. STATUS reads empty=1 after the second pop.
- While the first frame is active with FIFO_DEPTH=4:
  - write 5 more bytes → the 5th write sets overflow and count stays 4, and only the first 4 queued bytes are transmitted;
  - then write STATUS with bit3=1 → overflow reads 0.
- Read STATUS at offset 4, then read address BASE_ADDR+0x10 → STATUS returns 0x00000004 post-reset, and the out-of-window read returns 0. A write with MemRW=1 outside the window leaves count unchanged.
- Assert rst for 1 cycle mid-DATA with 3 bytes queued → tx=1 immediately (async). Then STATUS=0x00000004, BAUDDIV=16, and no further frames are sent.
- Write BAUDDIV=0 → reads back 2. Change BAUDDIV from 4 to 8 mid-frame → the current bit still lasts 4 cycles, and subsequent bits last 8.
